// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS MEM stage: opcodes WB cares about,
// access-FSM state encoding, abort poison word and the EX/MEM register layout.
package mem_stage_pkg;

    localparam logic [5:0]  OP_LW  = 6'h23;
    localparam logic [5:0]  OP_SW  = 6'h2B;
    localparam logic [5:0]  OP_JAL = 6'h03;

    localparam logic [31:0] POISON = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_ERR_DRAIN = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
        logic [5:0]  alu_op;
        logic [31:0] alu_out;
        logic [31:0] pc_branch;
        logic [4:0]  wb_addr;
    } ex_mem_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: issues lw/sw to a handshaked RAM, times out
// missing acks, flags misaligned addresses and produces the pipeline stall.
// Ports: clk_i/rst_i; mem_op_i/we_i/addr_i/wdata_i = captured EX request;
// mem_ack_i/mem_rdata_i = RAM response; mem_*_o = RAM request (registered);
// stall_o = freeze upstream; kill_o = suppress WB of aborted instruction;
// err_o = sticky error; rdata_o = load data (or poison on timeout).
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_op_i,
    input  logic              we_i,
    input  logic [ADDR_W+1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              stall_o,
    output logic              kill_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              err_o,
    output logic [31:0]       rdata_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mem_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              kill_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    // Only IDLE lets the EX/MEM register capture, so every IDLE edge is a
    // capture edge; that is also where the kill of a drained instruction ends.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    kill_q <= 1'b0;
                    if (mem_op_i) begin
                        if (addr_i[1:0] == 2'b00) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= '0;
                            req_q   <= 1'b1;
                            we_q    <= we_i;
                            addr_q  <= addr_i[ADDR_W+1:2];
                            wdata_q <= wdata_i;
                        end else begin
                            state_q <= ST_ERR_DRAIN;
                            err_q   <= 1'b1;
                            kill_q  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (!we_q) rdata_q <= mem_rdata_i;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_ERR_DRAIN;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        kill_q  <= 1'b1;
                        if (!we_q) rdata_q <= POISON;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ERR_DRAIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall depends on state only, so mem_ack never reaches upstream enables.
    assign stall_o     = (state_q == ST_WAIT) | (state_q == ST_ERR_DRAIN);
    assign kill_o      = kill_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, data-memory access
// and WB/IF-facing outputs. Inputs *E/*_in come from EX; *M/*_M go to WB/IF;
// mem_* is the data-RAM handshake; StallM freezes IF/ID/EX; mem_err is sticky.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic [5:0]        ALUopE,
    input  logic [31:0]       ALUOut_in,
    input  logic [31:0]       WriteData_in,
    input  logic [31:0]       PCBranch_in,
    input  logic [4:0]        wb_addr_in,
    output logic              StallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              BranchM,
    output logic              JumpM,
    output logic [5:0]        ALUopM,
    output logic [31:0]       ALUOutM,
    output logic [31:0]       ReadDataM,
    output logic [31:0]       PCBranchM,
    output logic [4:0]        wb_addr_M,
    output logic              mem_err
);

    ex_mem_t ex_mem_q;
    ex_mem_t ex_mem_d;
    logic    kill;

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!StallM) begin
            ex_mem_d.reg_write  = RegWriteE;
            ex_mem_d.mem_to_reg = MemtoRegE;
            ex_mem_d.branch     = BranchE;
            ex_mem_d.jump       = JumpE;
            ex_mem_d.alu_op     = ALUopE;
            ex_mem_d.alu_out    = ALUOut_in;
            ex_mem_d.pc_branch  = PCBranch_in;
            ex_mem_d.wb_addr    = wb_addr_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) ex_mem_q <= '0;
        else       ex_mem_q <= ex_mem_d;
    end

    mem_access_fsm #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fsm (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .mem_op_i    (MemtoRegE | MemWriteE),
        .we_i        (MemWriteE),
        .addr_i      (ALUOut_in[ADDR_W+1:0]),
        .wdata_i     (WriteData_in),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .stall_o     (StallM),
        .kill_o      (kill),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .err_o       (mem_err),
        .rdata_o     (ReadDataM)
    );

    // Bubble WB while the access is pending and after an aborted access,
    // so an instruction writes the register file exactly once (or never).
    assign RegWriteM = ex_mem_q.reg_write  & ~StallM & ~kill;
    assign MemtoRegM = ex_mem_q.mem_to_reg & ~StallM & ~kill;
    assign BranchM   = ex_mem_q.branch;
    assign JumpM     = ex_mem_q.jump;
    assign ALUopM    = ex_mem_q.alu_op;
    assign ALUOutM   = ex_mem_q.alu_out;
    assign PCBranchM = ex_mem_q.pc_branch;
    assign wb_addr_M = ex_mem_q.wb_addr;

endmodule
